// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: tracks in-flight register writers, issues EX forward selects, stall/bubble/flush/freeze controls.
// Latency: fwd selects registered (valid the cycle the ID instruction reaches EX); pipeline enables are combinational.
// Backpressure: mdu_busy freezes everything; a load-use stall holds PC and IF/ID and injects a bubble into ID/EX.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   id_*                          decoded ID-stage instruction (sources, destination, load flag)
//   ex_redirect, mdu_busy         taken branch in EX, multicycle-unit freeze
//   pc_write .. idex_bubble       pipeline register enables / clears
//   fwd_a_sel, fwd_b_sel          EX operand sources (0 = ID/EX value, k = post-EX stage k)
//   stall_cnt                     saturating load-use stall cycle count
module hazard_fwd_ctrl #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_addr,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    input  logic              mdu_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_bubble,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Scoreboard entries 0 (EX) .. FWD_STAGES-1. The oldest stage writes the
    // RF and reaches ID through write-through, so it never needs to be searched
    // and is not stored.
    logic [FWD_STAGES-1:0] sb_vld_q;
    logic [FWD_STAGES-1:0] sb_ld_q;
    logic [REG_AW-1:0]     sb_addr_q [FWD_STAGES];

    logic [SEL_W-1:0] fwd_a_sel_q, fwd_a_sel_d;
    logic [SEL_W-1:0] fwd_b_sel_q, fwd_b_sel_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [SEL_W-1:0] cand_a, cand_b;
    logic             haz_a, haz_b;
    logic             stall;
    logic             insert_nop;

    // Returns {hazard, select} for one source. Searching from the oldest entry
    // down lets the youngest matching writer overwrite older matches.
    function automatic logic [SEL_W:0] lookup(input logic [REG_AW-1:0] src,
                                              input logic              uses);
        logic [SEL_W-1:0] sel;
        logic             hz;
        sel = '0;
        hz  = 1'b0;
        if (uses && (src != '0)) begin
            for (int j = FWD_STAGES - 1; j >= 0; j--) begin
                if (sb_vld_q[j] && (sb_addr_q[j] == src)) begin
                    sel = SEL_W'(j + 1);
                    // Load data only exists once the load has left stage LOAD_LAT.
                    hz  = sb_ld_q[j] && (j < LOAD_LAT);
                end
            end
        end
        return {hz, sel};
    endfunction

    always_comb begin
        {haz_a, cand_a} = lookup(id_rs, id_uses_rs);
        {haz_b, cand_b} = lookup(id_rt, id_uses_rt);
        stall           = id_valid && (haz_a || haz_b);
        insert_nop      = ex_redirect || stall;

        fwd_a_sel_d = insert_nop ? '0 : cand_a;
        fwd_b_sel_d = insert_nop ? '0 : cand_b;
        // A redirect squashes the stalled instruction, so that cycle is not a stall.
        stall_cnt_d = stall_cnt_q;
        if (stall && !ex_redirect && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_write  = 1'b0;
        idex_bubble = 1'b0;
        if (rst_n && !mdu_busy) begin
            if (ex_redirect) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_write  = 1'b1;
                idex_bubble = 1'b1;
            end else if (stall) begin
                idex_write  = 1'b1;
                idex_bubble = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_write  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_vld_q    <= '0;
            sb_ld_q     <= '0;
            for (int k = 0; k < FWD_STAGES; k++) begin
                sb_addr_q[k] <= '0;
            end
            fwd_a_sel_q <= '0;
            fwd_b_sel_q <= '0;
            stall_cnt_q <= '0;
        end else if (!mdu_busy) begin
            for (int k = FWD_STAGES - 1; k >= 1; k--) begin
                sb_vld_q[k]  <= sb_vld_q[k-1];
                sb_ld_q[k]   <= sb_ld_q[k-1];
                sb_addr_q[k] <= sb_addr_q[k-1];
            end
            // Writes to $0 are discarded so they can never be forwarded.
            sb_vld_q[0]  <= !insert_nop && id_valid && id_wr_en && (id_wr_addr != '0);
            sb_ld_q[0]   <= id_is_load;
            sb_addr_q[0] <= id_wr_addr;
            fwd_a_sel_q  <= fwd_a_sel_d;
            fwd_b_sel_q  <= fwd_b_sel_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign fwd_a_sel = fwd_a_sel_q;
    assign fwd_b_sel = fwd_b_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Testbench: two configurations (FWD=2/LL=1/CNT=16 and FWD=3/LL=2/CNT=2) driven by shared stimulus.
// Latency: each cycle's outputs compared at the falling edge against a queue-based reference model.
// Backpressure: mdu_busy and ex_redirect are part of the random stimulus.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load;
    logic [4:0] id_rs, id_rt, id_wr_addr;
    logic       ex_redirect, mdu_busy;

    logic       pc_write0, ifid_write0, ifid_flush0, idex_write0, idex_bubble0;
    logic       pc_write1, ifid_write1, ifid_flush1, idex_write1, idex_bubble1;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_AW(5), .FWD_STAGES(2), .LOAD_LAT(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
        .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .mdu_busy(mdu_busy), .pc_write(pc_write0), .ifid_write(ifid_write0),
        .ifid_flush(ifid_flush0), .idex_write(idex_write0), .idex_bubble(idex_bubble0),
        .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stall_cnt(cnt0));

    hazard_fwd_ctrl #(.REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
        .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .mdu_busy(mdu_busy), .pc_write(pc_write1), .ifid_write(ifid_write1),
        .ifid_flush(ifid_flush1), .idex_write(idex_write1), .idex_bubble(idex_bubble1),
        .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_cnt(cnt1));

    // Observed values per configuration, widened for comparison.
    logic [31:0] obs_ctrl [2];
    logic [31:0] obs_fa   [2];
    logic [31:0] obs_fb   [2];
    logic [31:0] obs_cnt  [2];
    assign obs_ctrl[0] = {27'd0, pc_write0, ifid_write0, ifid_flush0, idex_write0, idex_bubble0};
    assign obs_ctrl[1] = {27'd0, pc_write1, ifid_write1, ifid_flush1, idex_write1, idex_bubble1};
    assign obs_fa[0]   = {30'd0, fa0};
    assign obs_fa[1]   = {30'd0, fa1};
    assign obs_fb[0]   = {30'd0, fb0};
    assign obs_fb[1]   = {30'd0, fb1};
    assign obs_cnt[0]  = {16'd0, cnt0};
    assign obs_cnt[1]  = {30'd0, cnt1};

    // Reference model: a queue of in-flight writers, youngest at the front.
    typedef struct packed {
        logic       v;
        logic [4:0] a;
        logic       ld;
    } ent_t;
    typedef ent_t ent_q_t[$];

    ent_q_t sb0, sb1;
    int     m_fa  [2];
    int     m_fb  [2];
    int     m_cnt [2];
    int     P_FWD [2] = '{2, 3};
    int     P_LL  [2] = '{1, 2};
    int     P_MAX [2] = '{65535, 3};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Producer search: first (youngest) matching writer among the forwardable stages.
    function automatic void search(input ent_q_t q, input int fwd, input int ll,
                                   input logic [4:0] s, input logic uses,
                                   output int sel, output bit hz);
        sel = 0;
        hz  = 1'b0;
        if (uses) begin
            for (int j = 0; j < q.size() && j < fwd; j++) begin
                if (q[j].v && q[j].a == s) begin
                    sel = j + 1;
                    hz  = q[j].ld && (sel < ll + 1);
                    break;
                end
            end
        end
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}
    function automatic logic [31:0] exp_ctrl(input bit busy, input bit redir, input bit stall);
        if (busy)  return 32'b00000;
        if (redir) return 32'b11111;
        if (stall) return 32'b00011;
        return 32'b11010;
    endfunction

    task automatic model_cfg(input int c);
        ent_q_t q;
        ent_t   e;
        int     sa, sb;
        bit     ha, hb, stall, nop;
        if (c == 0) q = sb0; else q = sb1;
        search(q, P_FWD[c], P_LL[c], id_rs, id_uses_rs, sa, ha);
        search(q, P_FWD[c], P_LL[c], id_rt, id_uses_rt, sb, hb);
        stall = id_valid && (ha || hb);
        check_eq($sformatf("ctrl%0d", c), obs_ctrl[c], exp_ctrl(mdu_busy, ex_redirect, stall));
        check_eq($sformatf("fwd_a%0d", c), obs_fa[c], m_fa[c]);
        check_eq($sformatf("fwd_b%0d", c), obs_fb[c], m_fb[c]);
        check_eq($sformatf("cnt%0d", c), obs_cnt[c], m_cnt[c]);
        if (!mdu_busy) begin
            nop  = ex_redirect || stall;
            e.v  = !nop && id_valid && id_wr_en && (id_wr_addr != 5'd0);
            e.a  = id_wr_addr;
            e.ld = id_is_load;
            q.push_front(e);
            while (q.size() > P_FWD[c]) void'(q.pop_back());
            m_fa[c] = nop ? 0 : sa;
            m_fb[c] = nop ? 0 : sb;
            if (stall && !ex_redirect && m_cnt[c] < P_MAX[c]) m_cnt[c]++;
        end
        if (c == 0) sb0 = q; else sb1 = q;
    endtask

    task automatic model_reset();
        sb0.delete();
        sb1.delete();
        for (int c = 0; c < 2; c++) begin
            m_fa[c] = 0; m_fb[c] = 0; m_cnt[c] = 0;
        end
    endtask

    // Inputs were driven just after a rising edge; check at the falling edge,
    // advance the model, then move to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        model_cfg(0);
        model_cfg(1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input bit wr, input int wa, input bit ld, input bit rd, input bit busy);
        id_valid    = v;
        id_rs       = 5'(rs);
        id_rt       = 5'(rt);
        id_uses_rs  = urs;
        id_uses_rt  = urt;
        id_wr_en    = wr;
        id_wr_addr  = 5'(wa);
        id_is_load  = ld;
        ex_redirect = rd;
        mdu_busy    = busy;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int c = 0; c < 2; c++) begin
            check_eq($sformatf("%s_ctrl%0d", tag, c), obs_ctrl[c], 0);
            check_eq($sformatf("%s_fa%0d", tag, c), obs_fa[c], 0);
            check_eq($sformatf("%s_fb%0d", tag, c), obs_fb[c], 0);
            check_eq($sformatf("%s_cnt%0d", tag, c), obs_cnt[c], 0);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        check_reset_outputs("rst");
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: forwarding distances, $0 writes, load-use, redirect in stall, freeze.
        drive(1, 1, 2, 1, 1, 1, 3, 0, 0, 0); step();   // add $3,$1,$2
        drive(1, 3, 1, 1, 1, 1, 4, 0, 0, 0); step();   // sub $4,$3,$1 -> a=1
        drive(1, 1, 3, 1, 1, 1, 3, 0, 0, 0); step();   // add $3 again
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();   // nop
        drive(1, 1, 3, 1, 1, 1, 5, 0, 0, 0); step();   // or $5,$1,$3 -> b=2
        drive(1, 1, 1, 1, 1, 1, 0, 0, 0, 0); step();   // write to $0
        drive(1, 0, 0, 1, 1, 1, 7, 0, 0, 0); step();   // reads $0 -> 0
        drive(1, 1, 0, 1, 0, 1, 2, 1, 0, 0); step();   // lw $2
        for (int i = 0; i < 4; i++) begin
            drive(1, 2, 2, 1, 1, 1, 6, 0, 0, 0); step(); // add $6,$2,$2 (stalls, then fwd)
        end
        drive(1, 1, 0, 1, 0, 1, 2, 1, 0, 0); step();   // lw $2
        drive(1, 2, 2, 1, 1, 1, 6, 0, 1, 0); step();   // redirect during load-use
        drive(1, 1, 2, 1, 1, 1, 3, 0, 0, 0); step();   // add $3
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 3, 1, 1, 1, 4, 0, 0, 1); step(); // freeze
        end
        drive(1, 3, 3, 1, 1, 1, 4, 0, 0, 0); step();

        // Reset asserted asynchronously in the middle of a load-use stall.
        drive(1, 1, 0, 1, 0, 1, 2, 1, 0, 0); step();   // lw $2
        drive(1, 2, 2, 1, 1, 1, 6, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 2, 2, 1, 1, 1, 6, 0, 0, 0); step();   // empty scoreboard: selects 0 next
        drive(1, 6, 2, 1, 1, 1, 8, 0, 0, 0); step();

        // Randomized traffic with a small register set so matches are frequent.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(7, 0) != 0,
                  $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
                  $urandom_range(3, 0) != 0, $urandom_range(3, 0),
                  $urandom_range(9, 0) < 4,
                  $urandom_range(9, 0) == 0,
                  $urandom_range(7, 0) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
